// File: rtl/cam_signal_gen.sv
// rtl/cam_signal_gen.sv - OV7670 camera bus emulator (QQVGA RGB444 frame generator)
module cam_signal_gen #(
  parameter int TAM_LINE       = 320,
  parameter int TAM_ROW        = 120,
  parameter int BLACK_TAM_LINE = 4,
  parameter int BLACK_TAM_ROW  = 4,
  parameter int PCLK_DIV       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic       CAM_pclk,
  output logic       CAM_vsync,
  output logic       CAM_href,
  output logic [7:0] CAM_px_data,
  output logic       frame_done
);

  localparam int         DIV_W     = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
  localparam logic [8:0] LINE_LAST = 9'(TAM_LINE + BLACK_TAM_LINE - 1);
  localparam logic [6:0] ROW_LAST  = 7'(TAM_ROW + BLACK_TAM_ROW - 1);
  localparam logic [8:0] ACT_LINE  = 9'(TAM_LINE);
  localparam logic [6:0] ACT_ROW   = 7'(BLACK_TAM_ROW);
  localparam logic [6:0] VS_ROWS   = 7'(BLACK_TAM_ROW / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [8:0]       line_cnt, line_n;
  logic [6:0]       row_cnt, row_n;
  logic [1:0]       pat, pat_n;
  logic [3:0]       frame_cnt, fcnt_n;
  logic             done_n;
  logic             div_wrap, strobe;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [11:0]      colour;
  logic             vsync_n, href_n;
  logic [7:0]       data_n;

  assign div_wrap = (div_cnt == DIV_LAST);
  // Falling pclk edge: the only moment pclk-derived outputs may change.
  assign strobe   = div_wrap && CAM_pclk;

  always_comb begin
    state_n = state;
    line_n  = line_cnt;
    row_n   = row_cnt;
    pat_n   = pat;
    fcnt_n  = frame_cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = RUN;
          line_n  = '0;
          row_n   = '0;
          pat_n   = pattern_sel;
        end
      end
      RUN: begin
        if (line_cnt == LINE_LAST) begin
          line_n = '0;
          if (row_cnt == ROW_LAST) begin
            row_n  = '0;
            done_n = 1'b1;
            fcnt_n = frame_cnt + 4'd1;
            if (en) pat_n = pattern_sel;
            else    state_n = IDLE;
          end else begin
            row_n = row_cnt + 7'd1;
          end
        end else begin
          line_n = line_cnt + 9'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are derived from the counter values that take effect at this strobe.
  always_comb begin
    x       = line_n[8:1];
    y       = row_n - ACT_ROW;
    vsync_n = (state_n == RUN) && (row_n < VS_ROWS);
    href_n  = (state_n == RUN) && (row_n >= ACT_ROW) && (line_n < ACT_LINE);
    colour  = 12'h00F;
    case (pat_n)
      2'd0: colour = 12'h00F;
      2'd1: begin
        if      (x < 8'd20)  colour = 12'hFFF;
        else if (x < 8'd40)  colour = 12'hFF0;
        else if (x < 8'd60)  colour = 12'h0FF;
        else if (x < 8'd80)  colour = 12'h0F0;
        else if (x < 8'd100) colour = 12'hF0F;
        else if (x < 8'd120) colour = 12'hF00;
        else if (x < 8'd140) colour = 12'h00F;
        else                 colour = 12'h000;
      end
      2'd2: begin
        if      (y < 7'd15)  colour = 12'hF0F;
        else if (y < 7'd45)  colour = 12'h0F0;
        else if (y < 7'd75)  colour = 12'hF0F;
        else if (y < 7'd105) colour = 12'h0F0;
        else                 colour = 12'hF0F;
      end
      default: colour = {x[3:0], y[3:0], fcnt_n};
    endcase
    if (!href_n)        data_n = 8'h00;
    else if (line_n[0]) data_n = colour[7:0];
    else                data_n = {4'h0, colour[11:8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      line_cnt    <= '0;
      row_cnt     <= '0;
      pat         <= '0;
      frame_cnt   <= '0;
      CAM_pclk    <= 1'b0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
      frame_done <= 1'b0;
      if (div_wrap) CAM_pclk <= ~CAM_pclk;
      if (strobe) begin
        state       <= state_n;
        line_cnt    <= line_n;
        row_cnt     <= row_n;
        pat         <= pat_n;
        frame_cnt   <= fcnt_n;
        frame_done  <= done_n;
        CAM_vsync   <= vsync_n;
        CAM_href    <= href_n;
        CAM_px_data <= data_n;
      end
    end
  end

endmodule

// File: tb/tb_cam_signal_gen.sv
// tb/tb_cam_signal_gen.sv - directed bench for cam_signal_gen (shortened frame height)
module tb_cam_signal_gen;

  localparam int ROWS       = 8;
  localparam int LINES      = 324;
  localparam int FRAME_ROWS = ROWS + 4;
  localparam int FRAME_POS  = LINES * FRAME_ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0] CAM_px_data;

  int         n_vec = 0;
  int         n_miss = 0;
  int         done_cnt = 0;
  int         cur_row = 0;
  int         cur_line = 0;
  int         waited;
  logic [7:0] smp_data;

  cam_signal_gen #(
    .TAM_LINE(320), .TAM_ROW(ROWS), .BLACK_TAM_LINE(4), .BLACK_TAM_ROW(4), .PCLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s (row %0d line %0d): got %0h, expected %0h", tag, cur_row, cur_line, got, exp);
    end
  endtask

  // Returns at the negedge after the next rising pclk edge; n = clk cycles waited.
  task automatic wait_rise(output int n);
    n = 0;
    while (CAM_pclk !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    while (CAM_pclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (CAM_pclk !== 1'b1) chk("pclk_rise_timeout", CAM_pclk, 1);
  endtask

  task automatic wait_vsync();
    int n = 0;
    while (CAM_vsync !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (CAM_vsync !== 1'b1) chk("vsync_start_timeout", CAM_vsync, 1);
    cur_row  = 0;
    cur_line = 0;
  endtask

  function automatic logic [9:0] model(input int pat, input int fc, input int row, input int line);
    logic [11:0] c;
    logic        vs, hr;
    logic [7:0]  d;
    int          x, y;
    x = line / 2;
    y = row - 4;
    case (pat)
      0: c = 12'h00F;
      1: case (x / 20)
           0: c = 12'hFFF;
           1: c = 12'hFF0;
           2: c = 12'h0FF;
           3: c = 12'h0F0;
           4: c = 12'hF0F;
           5: c = 12'hF00;
           6: c = 12'h00F;
           default: c = 12'h000;
         endcase
      2: c = (y < 15) ? 12'hF0F : (y < 45) ? 12'h0F0 : (y < 75) ? 12'hF0F :
             (y < 105) ? 12'h0F0 : 12'hF0F;
      default: c = {4'(x), 4'(y), 4'(fc)};
    endcase
    vs = (row < 2);
    hr = (row >= 4) && (line < 320);
    d  = !hr ? 8'h00 : (line % 2 == 1) ? c[7:0] : {4'h0, c[11:8]};
    return {vs, hr, d};
  endfunction

  task automatic step(input int pat, input int fc);
    logic [9:0] e;
    int n;
    wait_rise(n);
    e = model(pat, fc, cur_row, cur_line);
    chk("vsync", CAM_vsync, e[9]);
    chk("href", CAM_href, e[8]);
    chk("data", CAM_px_data, e[7:0]);
    smp_data = CAM_px_data;
    if (cur_line == LINES - 1) begin
      cur_line = 0;
      cur_row  = (cur_row == FRAME_ROWS - 1) ? 0 : cur_row + 1;
    end else begin
      cur_line++;
    end
  endtask

  task automatic idle_check(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      wait_rise(n);
      chk("idle_vsync", CAM_vsync, 0);
      chk("idle_href", CAM_href, 0);
      chk("idle_data", CAM_px_data, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pclk", CAM_pclk, 0);
    chk("rst_vsync", CAM_vsync, 0);
    chk("rst_href", CAM_href, 0);
    chk("rst_data", CAM_px_data, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;

    wait_rise(waited);
    wait_rise(waited);
    chk("pclk_period", waited, 4);
    idle_check(4);

    en = 1'b1;
    pattern_sel = 2'd0;
    wait_vsync();
    for (int p = 0; p < FRAME_POS; p++) begin
      step(0, 0);
      if (p == 1000) pattern_sel = 2'd1;
    end

    for (int p = 0; p < FRAME_POS; p++) begin
      step(1, 1);
      if (p == 0) chk("frame_done_a", done_cnt, 1);
      if (p == 4 * LINES + 38)  chk("bar_b38", smp_data, 8'h0F);
      if (p == 4 * LINES + 39)  chk("bar_b39", smp_data, 8'hFF);
      if (p == 4 * LINES + 40)  chk("bar_b40", smp_data, 8'h0F);
      if (p == 4 * LINES + 41)  chk("bar_b41", smp_data, 8'hF0);
      if (p == 4 * LINES + 318) chk("bar_b318", smp_data, 8'h00);
      if (p == 4 * LINES + 319) chk("bar_b319", smp_data, 8'h00);
      if (p == 1000) pattern_sel = 2'd2;
    end

    for (int p = 0; p < FRAME_POS; p++) begin
      step(2, 2);
      if (p == 0) chk("frame_done_b", done_cnt, 2);
      if (p == 4 * LINES + 1) chk("stripe_b1", smp_data, 8'h0F);
      if (p == 6 * LINES) begin
        en = 1'b0;
        pattern_sel = 2'd3;
      end
    end
    idle_check(20);
    chk("frame_done_c", done_cnt, 3);

    en = 1'b1;
    wait_vsync();
    for (int p = 0; p <= 5 * LINES + 100; p++) begin
      step(3, 3);
      if (p == 5 * LINES + 36) chk("ramp_b36", smp_data, 8'h02);
      if (p == 5 * LINES + 37) chk("ramp_b37", smp_data, 8'h13);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pclk", CAM_pclk, 0);
    chk("abort_vsync", CAM_vsync, 0);
    chk("abort_href", CAM_href, 0);
    chk("abort_data", CAM_px_data, 0);
    chk("abort_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_vsync();
    for (int p = 0; p < 6 * LINES; p++) begin
      step(3, 0);
      if (p == 4 * LINES + 37) chk("ramp_restart_b37", smp_data, 8'h00);
    end
    chk("frame_done_final", done_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
